// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and parameter checks for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  function automatic bit legal_cfg(int unsigned data_bits, int unsigned stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) && (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the transmitter: byte strobe in, FIFO status out.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 8
);
  logic                   ready;
  logic [DATA_BITS-1:0]   data;
  logic                   transmit_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  modport master (output ready, data, input transmit_ready, count, overflow);
  modport slave  (input ready, data, output transmit_ready, count, overflow);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with extra pointer MSB to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign rdata     = r_mem[r_rd_ptr[AW-1:0]];
  assign overflow  = r_overflow;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (push && !w_do_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM with baud counter and parity.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 10417,
  parameter int unsigned DATA_BITS = 8,
  parameter parity_t     PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 8
) (
  input  logic           clk,
  input  logic           Rst,
  uart_tx_fifo_if.slave  bus,
  output logic           tx_serial,
  output logic           tx_busy
);
  localparam int unsigned BAUD_W = $clog2(CLK_DIV);

  if (!legal_cfg(DATA_BITS, STOP_BITS) || CLK_DIV < 2 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal parameter set");
  end

  tx_state_t            r_state, w_state_nxt;
  logic [BAUD_W-1:0]    r_baud, w_baud_nxt;
  logic [3:0]           r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 w_pop, w_load, w_tick;
  logic [DATA_BITS-1:0] w_rdata;
  logic                 w_full, w_empty;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (Rst),
    .push    (bus.ready),
    .pop     (w_pop),
    .wdata   (bus.data),
    .rdata   (w_rdata),
    .full    (w_full),
    .empty   (w_empty),
    .count   (bus.count),
    .overflow(bus.overflow)
  );

  assign bus.transmit_ready = !w_full;
  assign tx_serial          = r_tx;
  assign tx_busy            = (r_state != IDLE);
  assign w_tick             = (r_baud == BAUD_W'(CLK_DIV - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      IDLE:  if (!w_empty) w_load = 1'b1;
      START: if (w_tick) begin
        w_state_nxt = DATA;
        w_idx_nxt   = '0;
      end
      DATA:  if (w_tick) begin
        if (r_idx == 4'(DATA_BITS - 1)) begin
          w_state_nxt = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          w_idx_nxt   = '0;
        end else begin
          w_shift_nxt = r_shift >> 1;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      uart_pkg::PARITY: if (w_tick) begin
        w_state_nxt = STOP;
        w_idx_nxt   = '0;
      end
      STOP:  if (w_tick) begin
        if (r_idx == 4'(STOP_BITS - 1)) begin
          if (!w_empty) w_load = 1'b1;
          else          w_state_nxt = IDLE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_load) begin
      w_pop       = 1'b1;
      w_shift_nxt = w_rdata;
      w_par_nxt   = (^w_rdata) ^ (PARITY == PAR_ODD);
      w_idx_nxt   = '0;
      w_state_nxt = START;
    end
    // Line level is computed for the state being entered so tx_serial stays registered.
    case (w_state_nxt)
      START:            w_tx_nxt = 1'b0;
      DATA:             w_tx_nxt = w_shift_nxt[0];
      uart_pkg::PARITY: w_tx_nxt = w_par_nxt;
      default:          w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: five configurations of uart_tx_fifo checked against hand-written line patterns.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned CD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy    [5];
  logic [7:0] dd     [5];
  logic       tx_w   [5];
  logic       busy_w [5];
  logic       tr_w   [5];
  logic       ov_w   [5];
  logic [3:0] cnt    [5];
  int         n_pass = 0;
  int         n_tot  = 0;

  always #5 clk = ~clk;

  // 0: 8N1 depth 8, 1: 8E1, 2: 8O1, 3: 8N1 depth 4, 4: 5N2
  uart_tx_fifo_if #(.DATA_BITS(8), .DEPTH(8)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .DEPTH(8)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .DEPTH(8)) if2 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .DEPTH(4)) if3 ();
  uart_tx_fifo_if #(.DATA_BITS(5), .DEPTH(8)) if4 ();

  assign if0.ready = rdy[0];  assign if0.data = dd[0];
  assign if1.ready = rdy[1];  assign if1.data = dd[1];
  assign if2.ready = rdy[2];  assign if2.data = dd[2];
  assign if3.ready = rdy[3];  assign if3.data = dd[3];
  assign if4.ready = rdy[4];  assign if4.data = dd[4][4:0];

  assign tr_w[0] = if0.transmit_ready; assign ov_w[0] = if0.overflow; assign cnt[0] = if0.count;
  assign tr_w[1] = if1.transmit_ready; assign ov_w[1] = if1.overflow; assign cnt[1] = if1.count;
  assign tr_w[2] = if2.transmit_ready; assign ov_w[2] = if2.overflow; assign cnt[2] = if2.count;
  assign tr_w[3] = if3.transmit_ready; assign ov_w[3] = if3.overflow; assign cnt[3] = {1'b0, if3.count};
  assign tr_w[4] = if4.transmit_ready; assign ov_w[4] = if4.overflow; assign cnt[4] = if4.count;

  uart_tx_fifo #(.CLK_DIV(CD)) u0 (
    .clk(clk), .Rst(rst), .bus(if0.slave), .tx_serial(tx_w[0]), .tx_busy(busy_w[0]));
  uart_tx_fifo #(.CLK_DIV(CD), .PARITY(PAR_EVEN)) u1 (
    .clk(clk), .Rst(rst), .bus(if1.slave), .tx_serial(tx_w[1]), .tx_busy(busy_w[1]));
  uart_tx_fifo #(.CLK_DIV(CD), .PARITY(PAR_ODD)) u2 (
    .clk(clk), .Rst(rst), .bus(if2.slave), .tx_serial(tx_w[2]), .tx_busy(busy_w[2]));
  uart_tx_fifo #(.CLK_DIV(CD), .DEPTH(4)) u3 (
    .clk(clk), .Rst(rst), .bus(if3.slave), .tx_serial(tx_w[3]), .tx_busy(busy_w[3]));
  uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(5), .STOP_BITS(2)) u4 (
    .clk(clk), .Rst(rst), .bus(if4.slave), .tx_serial(tx_w[4]), .tx_busy(busy_w[4]));

  typedef struct {
    int         sel;
    logic [7:0] d;
    string      line;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(string name, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Cycle t of a frame sequence carries character t/CD of s; busy must stay high throughout.
  task automatic check_span(int sel, string s, int t_from, int t_to);
    int   got;
    int   want;
    bit   seen;
    logic eb;
    got  = 0;
    want = 0;
    seen = 1'b0;
    for (int t = t_from; t <= t_to; t++) begin
      tick();
      eb = (s[t / CD] == "1");
      if (!seen) begin
        got  = {busy_w[sel], tx_w[sel]};
        want = {1'b1, eb};
        if (busy_w[sel] !== 1'b1 || tx_w[sel] !== eb) seen = 1'b1;
      end
    end
    chk($sformatf("line%0d_t%0d_%0d", sel, t_from, t_to), got, want);
  endtask

  task automatic check_frames(int sel, string s, int t_start);
    for (int b = 0; b < s.len(); b++) begin
      if (b * CD + CD - 1 >= t_start)
        check_span(sel, s, (b * CD > t_start) ? b * CD : t_start, b * CD + CD - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ws [6];
    string      s;
    int         ok;

    vecs[0] = '{0, 8'h41, "0100000101"};
    vecs[1] = '{0, 8'hA5, "0101001011"};
    vecs[2] = '{1, 8'h41, "01000001001"};
    vecs[3] = '{2, 8'h41, "01000001011"};
    vecs[4] = '{1, 8'h07, "01110000011"};
    vecs[5] = '{4, 8'h1F, "01111111"};
    vecs[6] = '{4, 8'h0A, "00101011"};
    vecs[7] = '{2, 8'h00, "00000000011"};

    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rdy[i] = 1'b0;
      dd[i]  = '0;
    end
    repeat (3) tick();
    chk("rst_tx",     tx_w[0],   1);
    chk("rst_busy",   busy_w[0], 0);
    chk("rst_count",  cnt[0],    0);
    chk("rst_ovf",    ov_w[0],   0);
    chk("rst_tready", tr_w[0],   1);
    chk("rst_tx_d4",  tx_w[3],   1);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      rdy[vecs[v].sel] = 1'b1;
      dd[vecs[v].sel]  = vecs[v].d;
      tick();
      rdy[vecs[v].sel] = 1'b0;
      chk($sformatf("v%0d_count_push", v), cnt[vecs[v].sel], 1);
      chk($sformatf("v%0d_busy_pre", v), busy_w[vecs[v].sel], 0);
      check_span(vecs[v].sel, vecs[v].line, 0, CD - 1);
      chk($sformatf("v%0d_count_pop", v), cnt[vecs[v].sel], 0);
      check_frames(vecs[v].sel, vecs[v].line, CD);
      tick();
      chk($sformatf("v%0d_busy_end", v), busy_w[vecs[v].sel], 0);
      chk($sformatf("v%0d_tx_end", v), tx_w[vecs[v].sel], 1);
    end

    // Back-to-back: three consecutive writes into depth 4, frames abut.
    s = {"0000100101", "0100000101", "0011100101"};
    rdy[3] = 1'b1;
    dd[3]  = 8'h48;
    tick();
    chk("b2b_count_k", cnt[3], 1);
    dd[3] = 8'h41;
    tick();
    chk("b2b_count_t0", cnt[3], 1);
    chk("b2b_tx_t0", tx_w[3], 0);
    dd[3] = 8'h4E;
    tick();
    rdy[3] = 1'b0;
    chk("b2b_count_t1", cnt[3], 2);
    chk("b2b_tx_t1", tx_w[3], 0);
    for (int b = 0; b < 30; b++) begin
      check_span(3, s, (b == 0) ? 2 : b * CD, b * CD + CD - 1);
      if (b == 9)  chk("b2b_count_a", cnt[3], 2);
      if (b == 10) chk("b2b_count_b", cnt[3], 1);
      if (b == 20) chk("b2b_count_c", cnt[3], 0);
    end
    tick();
    chk("b2b_busy_end", busy_w[3], 0);

    // Overflow: fill depth 4 while busy; two extra words are dropped.
    ws = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hEE, 8'hFF};
    s  = {"0100010001", "0100000001", "0010000001", "0110000001", "0001000001"};
    rdy[3] = 1'b1;
    dd[3]  = 8'h11;
    tick();
    rdy[3] = 1'b0;
    chk("ovf_count_k", cnt[3], 1);
    tick();
    chk("ovf_count_t0", cnt[3], 0);
    rdy[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dd[3] = ws[i];
      tick();
      if (i == 3) begin
        chk("ovf_count_full", cnt[3], 4);
        chk("ovf_tready_full", tr_w[3], 0);
        chk("ovf_flag_pre", ov_w[3], 0);
      end
    end
    rdy[3] = 1'b0;
    chk("ovf_count_after", cnt[3], 4);
    chk("ovf_tready_after", tr_w[3], 0);
    chk("ovf_flag", ov_w[3], 1);
    check_frames(3, s, 7);
    tick();
    chk("ovf_busy_end", busy_w[3], 0);
    chk("ovf_count_end", cnt[3], 0);
    chk("ovf_flag_sticky", ov_w[3], 1);
    chk("ovf_tready_end", tr_w[3], 1);

    // Mid-frame reset during data bit 3, with a second byte still queued.
    rdy[0] = 1'b1;
    dd[0]  = 8'h41;
    tick();
    dd[0] = 8'h42;
    tick();
    rdy[0] = 1'b0;
    chk("mrst_count_q", cnt[0], 1);
    check_span(0, "0100000101", 1, 16);
    rst = 1'b1;
    tick();
    chk("mrst_tx", tx_w[0], 1);
    chk("mrst_busy", busy_w[0], 0);
    chk("mrst_count", cnt[0], 0);
    rst = 1'b0;
    ok = 1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) ok = 0;
    end
    chk("mrst_quiet", {busy_w[0], tx_w[0], ok[0]}, 3'b011);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
